// File: rtl/io_bus_master_if.sv
// Core-side request/response handshake and peripheral address/control for
// io_bus_master. The shared tri-state data line is a plain inout port on the
// block itself, so it is not part of this interface.
interface io_bus_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_we
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_we
  );
endinterface

// File: rtl/io_bus_master.sv
// Single-outstanding load/store master for a simple tri-state peripheral bus.
// Misaligned requests are answered with an error and never reach the bus.
// Loads wait WAIT_STATES extra cycles before sampling the data line.
module io_bus_master #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  io_bus_master_if.master     bus,
  inout  wire  [31:0]         bus_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              bus_we_q, bus_we_d;

  // State and datapath registers.
  // NOTE: every register, including the captured request fields, is reset so
  // the outputs are defined the instant rst_n falls, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      cnt_q    <= 4'd0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      bus_we_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      bus_we_q <= bus_we_d;
    end
  end

  // Next-state logic: accept, run the bus access, hold the response.
  always_comb begin
    // NOTE: hold-by-default assignments first, so no path leaves a signal
    // unassigned and no latch is inferred.
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    bus_we_d = bus_we_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rdata_d = '0;
          if (bus.req_addr[1:0] != 2'b00) begin
            // Misaligned: answer immediately, the bus stays quiet.
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d    = 1'b0;
            addr_d   = bus.req_addr;
            wdata_d  = bus.req_wdata;
            write_d  = bus.req_write;
            bus_we_d = bus.req_write;
            cnt_d    = bus.req_write ? 4'd0 : 4'(WAIT_STATES);
            state_d  = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (write_q || cnt_q == 4'd0) begin
          // Stores always take one cycle; loads sample on their last cycle.
          rdata_d  = write_q ? 32'd0 : bus_data;
          bus_we_d = 1'b0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          // Returning to IDLE here gives the one-cycle turnaround bubble.
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs come from registers only; bus_we and the data driver share bus_we_q.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.bus_addr  = (state_q == ACCESS) ? addr_q : '0;
  assign bus.bus_we    = bus_we_q;
  assign bus_data      = bus_we_q ? wdata_q : 32'bz;

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: three instances (WAIT_STATES 1, 0, 15)
// share one stimulus source; 'sel' picks which instance sees the request and
// which one's outputs are observed. The bench plays the peripheral and drives
// resp_val onto a bus whenever that instance's bus_we is low.
module tb_io_bus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  int          sel;
  logic        req_valid, req_write, rsp_ready;
  logic [31:0] req_addr, req_wdata, resp_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_bus_master_if #(.ADDR_W(32)) if0 ();
  io_bus_master_if #(.ADDR_W(32)) if1 ();
  io_bus_master_if #(.ADDR_W(32)) if2 ();
  wire [31:0] bd0, bd1, bd2;

  assign if0.req_valid = req_valid & (sel == 0);
  assign if1.req_valid = req_valid & (sel == 1);
  assign if2.req_valid = req_valid & (sel == 2);
  assign if0.rsp_ready = rsp_ready & (sel == 0);
  assign if1.rsp_ready = rsp_ready & (sel == 1);
  assign if2.rsp_ready = rsp_ready & (sel == 2);
  assign if0.req_write = req_write;
  assign if1.req_write = req_write;
  assign if2.req_write = req_write;
  assign if0.req_addr  = req_addr;
  assign if1.req_addr  = req_addr;
  assign if2.req_addr  = req_addr;
  assign if0.req_wdata = req_wdata;
  assign if1.req_wdata = req_wdata;
  assign if2.req_wdata = req_wdata;

  // Peripheral side: drive the line only while the master is not writing.
  assign bd0 = if0.bus_we ? 32'bz : resp_val;
  assign bd1 = if1.bus_we ? 32'bz : resp_val;
  assign bd2 = if2.bus_we ? 32'bz : resp_val;

  io_bus_master #(.WAIT_STATES(1),  .ADDR_W(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .bus_data(bd0));
  io_bus_master #(.WAIT_STATES(0),  .ADDR_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .bus_data(bd1));
  io_bus_master #(.WAIT_STATES(15), .ADDR_W(32)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .bus_data(bd2));

  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_bus_we;
  logic [31:0] o_rsp_rdata, o_bus_addr, o_bus_data;

  always_comb begin
    o_req_ready = if0.req_ready;
    o_rsp_valid = if0.rsp_valid;
    o_rsp_err   = if0.rsp_err;
    o_rsp_rdata = if0.rsp_rdata;
    o_bus_we    = if0.bus_we;
    o_bus_addr  = if0.bus_addr;
    o_bus_data  = bd0;
    if (sel == 1) begin
      o_req_ready = if1.req_ready;
      o_rsp_valid = if1.rsp_valid;
      o_rsp_err   = if1.rsp_err;
      o_rsp_rdata = if1.rsp_rdata;
      o_bus_we    = if1.bus_we;
      o_bus_addr  = if1.bus_addr;
      o_bus_data  = bd1;
    end else if (sel == 2) begin
      o_req_ready = if2.req_ready;
      o_rsp_valid = if2.rsp_valid;
      o_rsp_err   = if2.rsp_err;
      o_rsp_rdata = if2.rsp_rdata;
      o_bus_we    = if2.bus_we;
      o_bus_addr  = if2.bus_addr;
      o_bus_data  = bd2;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  typedef struct {
    int          sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rval;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          we_cyc;
  } vec_t;

  // One complete transaction: request, per-cycle bus checks, latency, response, consume.
  task automatic do_txn(input vec_t v);
    int   n;
    int   we_cnt;
    logic vld;
    bit   done;
    @(negedge clk);
    sel       = v.sel;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    resp_val  = v.rval;
    rsp_ready = 1'b0;
    check("idle_req_ready", {31'd0, o_req_ready}, 32'd1);
    req_valid = 1'b1;
    @(posedge clk);
    n = 0; we_cnt = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      // Scramble core inputs: the captured copy must be what reaches the bus.
      req_valid = 1'b0;
      req_addr  = ~v.addr;
      req_wdata = ~v.wdata;
      req_write = ~v.wr;
      vld = o_rsp_valid;
      if (!vld) begin
        check("acc_bus_addr", o_bus_addr, v.addr);
        check("acc_bus_we", {31'd0, o_bus_we}, {31'd0, v.wr});
        check("acc_bus_data", o_bus_data, v.wr ? v.wdata : v.rval);
        if (o_bus_we) we_cnt++;
      end else begin
        check("resp_bus_we", {31'd0, o_bus_we}, 32'd0);
        check("resp_bus_addr", o_bus_addr, 32'd0);
        check("resp_bus_data", o_bus_data, v.rval);
      end
      @(posedge clk);
      n++;
      if (vld) done = 1'b1;
    end
    if (!done) fail_timeout("rsp_valid_wait");
    check("latency", n, v.lat);
    check("we_cycles", we_cnt, v.we_cyc);
    @(negedge clk);
    check("rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
    check("rsp_err", {31'd0, o_rsp_err}, {31'd0, v.err});
    check("rsp_rdata", o_rsp_rdata, v.rdata);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("back_in_idle", {31'd0, o_req_ready}, 32'd1);
    check("rsp_valid_clear", {31'd0, o_rsp_valid}, 32'd0);
  endtask

  // Wait (bounded) until the observed instance presents a response.
  task automatic wait_rsp(input string name);
    int k;
    k = 0;
    while (!o_rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!o_rsp_valid) fail_timeout(name);
  endtask

  vec_t vecs[10];

  initial begin
    //          sel wr addr          wdata         rval          lat err rdata         we
    vecs[0] = '{0, 1'b1, 32'h0,        32'h3FF,      32'h0F0F0F0F, 2,  1'b0, 32'h0,        1};
    vecs[1] = '{0, 1'b0, 32'h8,        32'h0,        32'h155,      3,  1'b0, 32'h155,      0};
    vecs[2] = '{0, 1'b0, 32'h6,        32'h0,        32'h777,      1,  1'b1, 32'h0,        0};
    vecs[3] = '{0, 1'b1, 32'h1001,     32'hABCD,     32'h0F0F0F0F, 1,  1'b1, 32'h0,        0};
    vecs[4] = '{0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'hDEADBEEF, 3,  1'b0, 32'hDEADBEEF, 0};
    vecs[5] = '{0, 1'b1, 32'h40,       32'h12345678, 32'h0F0F0F0F, 2,  1'b0, 32'h0,        1};
    vecs[6] = '{1, 1'b0, 32'h10,       32'h0,        32'hCAFEF00D, 2,  1'b0, 32'hCAFEF00D, 0};
    vecs[7] = '{2, 1'b0, 32'h20,       32'h0,        32'hA5A5A5A5, 17, 1'b0, 32'hA5A5A5A5, 0};
    vecs[8] = '{1, 1'b1, 32'h4,        32'h11,       32'h0F0F0F0F, 2,  1'b0, 32'h0,        1};
    vecs[9] = '{2, 1'b1, 32'h8,        32'h22,       32'h0F0F0F0F, 2,  1'b0, 32'h0,        1};

    sel = 0; req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; resp_val = 32'h5A5A5A5A;
    rst_n = 1'b0;

    // Reset state.
    #12;
    check("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
    check("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    check("rst_bus_we", {31'd0, o_bus_we}, 32'd0);
    check("rst_bus_addr", o_bus_addr, 32'd0);
    check("rst_bus_data_released", o_bus_data, 32'h5A5A5A5A);
    @(negedge clk);
    rst_n = 1'b1;

    // rsp_ready outside RESP does nothing.
    rsp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_rsp_ready_valid", {31'd0, o_rsp_valid}, 32'd0);
      check("idle_rsp_ready_ready", {31'd0, o_req_ready}, 32'd1);
    end
    rsp_ready = 1'b0;

    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // Response stall, then the turnaround bubble with req_valid held high.
    @(negedge clk);
    sel = 0; req_write = 1'b0; req_addr = 32'h8; req_wdata = '0;
    resp_val = 32'h155; rsp_ready = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_rsp("stall_wait");
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
      check("stall_rsp_rdata", o_rsp_rdata, 32'h155);
      check("stall_req_ready", {31'd0, o_req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bubble_idle", {31'd0, o_req_ready}, 32'd1);
    check("bubble_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("bubble_accepted", {31'd0, o_req_ready}, 32'd0);
    check("bubble_bus_addr", o_bus_addr, 32'h8);
    wait_rsp("bubble_wait");
    check("bubble_rdata", o_rsp_rdata, 32'h155);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during a store ACCESS cycle.
    @(negedge clk);
    sel = 0; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hFFFF0000;
    resp_val = 32'h5A5A5A5A; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_bus_we", {31'd0, o_bus_we}, 32'd1);
    check("pre_rst_bus_data", o_bus_data, 32'hFFFF0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bus_we", {31'd0, o_bus_we}, 32'd0);
    check("mid_rst_bus_addr", o_bus_addr, 32'd0);
    check("mid_rst_bus_data", o_bus_data, 32'h5A5A5A5A);
    check("mid_rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_ready", {31'd0, o_req_ready}, 32'd1);
      check("post_rst_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
    end
    do_txn(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
